alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential issue controller that drives the shifter/ALU datapath from the instruction side. Accepts 16-bit instruction words over a valid/ready handshake, reads operands from an internal 8×8-bit register file, and drives the `shifterAndALU` control and operand inputs. It writes the returned result back to the register file and reports retirement. It is the initiating end of the datapath's operand/control interface.

## Interface
Parameters:
- NREG, 8, register count (fixed; 3-bit addresses)
- W, 8, data width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr  in  16  [15] selOut, [14:12] oper, [11] selShiftAmt, [10:8] rd, [7:5] rs1, [4:2] rs2/shiftImm, [1:0] reserved (must be 0)
- instr_ready  out  1  controller can accept
- ld_en  in  1  host register load
- ld_addr  in  3  load address
- ld_data  in  8  load data
- rd_addr  in  3  readback address
- rd_data  out  8  combinational readback R[rd_addr]
- alu_inp1  out  8  to datapath inp1
- alu_inp2  out  8  to datapath inp2
- alu_shiftImm  out  3  to datapath shiftlmm
- alu_selShiftAmt  out  1  to datapath selShiftAmt
- alu_oper  out  3  to datapath oper
- alu_selOut  out  1  to datapath selOut
- alu_result  in  8  datapath out
- done  out  1  one-cycle retire pulse
- result  out  8  value written, valid with done
- err  out  1  one-cycle illegal-instruction pulse
- retired  out  8  count of successful writebacks, wraps 255→0

## Operation
- States: IDLE, READ, EXEC.
- IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr → READ.
- Legality check at acceptance: oper>5 or instr[1:0]≠0 is illegal. No state change (stay IDLE), no RF write, err=1 next cycle, retired unchanged.
- READ: operand registers load R[rs1]→alu_inp1, R[rs2]→alu_inp2. instr[4:2]→alu_shiftImm. Latched selOut/oper/selShiftAmt drive their ports. → EXEC.
- EXEC: datapath outputs stable. At the end of cycle, R[rd]←alu_result, result←alu_result, retired+1 (mod 256). → IDLE, done=1 in that first IDLE cycle.
- alu_* outputs hold their last values outside READ/EXEC (no glitch to zero).
- ld_en: honored only in IDLE; ignored in READ/EXEC. ld_en and acceptance in the same IDLE cycle: the load completes at that edge, and READ sees the loaded value. This also holds when ld_addr equals rs1/rs2.
- rd==rs1 or rd==rs2: operands are already latched in READ, so writeback does not disturb them.
- Arithmetic is performed entirely by the datapath. The controller stores the 8-bit result unmodified; no flags.

## Timing
- Reset (async, immediate):
  - state IDLE, instr_ready=1
  - all RF entries 0
  - alu_* = 0, result=0, done=0, err=0, retired=0
- Reset mid-READ/EXEC: instruction aborted; no writeback, no done.
- Latency: accept at edge E0; READ cycle E0–E1; EXEC E1–E2; RF write at E2; done/result visible E2–E3.
- Throughput: one instruction per 3 cycles. instr_ready is 0 during READ and EXEC. The next accept can occur in the done cycle.
- err pulses in the cycle after the illegal accept. instr_ready stays 1, so back-to-back offers are possible.
- done and err never assert together.

## Test plan
- Load R1=80, R2=20. Instr ADD (selOut=0, oper=1, rd=3, rs1=1, rs2=2) → alu_inp1=80, alu_inp2=20 during EXEC; done 3 cycles after accept; result=100; rd_data(3)=100; retired=1.
- R1=80, shift (selOut=1, oper=1, selShiftAmt=1, imm=2, rd=4) → alu_shiftImm=2; result=20 (arithmetic right); R4=20.
- R1=15, R2=26, SUB rd=5 → result=245. Then R1=150, R2=150, ADD → result=44.
- oper=6 offered → err=1 next cycle, no done, all registers unchanged, retired unchanged. instr[1:0]=2'b01 → same.
- Two valid instructions held back-to-back → instr_ready low for 2 cycles between accepts; second accept coincides with first done. ld_en during EXEC ignored (register unchanged).
- Assert reset during EXEC of ADD rd=3 → R3=0, done never pulses, instr_ready=1 after reset release. ld_en with accept of rs1=ld_addr in the same cycle → READ uses the loaded value.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts 16-bit instruction words, reads operands from an
// 8-entry register file, drives the shifter/ALU datapath and writes its result
// back. Each legal instruction takes IDLE -> READ -> EXEC -> IDLE; an illegal
// one is rejected in IDLE with a one-cycle err pulse.
module alu_issue_ctrl #(
  parameter int NREG = 8,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         instr_valid,
  input  logic [15:0]  instr,
  output logic         instr_ready,
  input  logic         ld_en,
  input  logic [2:0]   ld_addr,
  input  logic [W-1:0] ld_data,
  input  logic [2:0]   rd_addr,
  output logic [W-1:0] rd_data,
  output logic [W-1:0] alu_inp1,
  output logic [W-1:0] alu_inp2,
  output logic [2:0]   alu_shiftImm,
  output logic         alu_selShiftAmt,
  output logic [2:0]   alu_oper,
  output logic         alu_selOut,
  input  logic [W-1:0] alu_result,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err,
  output logic [7:0]   retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t       state;
  state_t       next_state;
  logic         accept;
  logic         legal;
  logic [2:0]   rs1_q;
  logic [2:0]   rs2_q;
  logic [2:0]   rd_q;
  logic [W-1:0] rf [NREG];

  // Opcodes 6 and 7 are undefined, and the reserved low bits must be clear.
  assign legal       = (instr[14:12] <= 3'd5) && (instr[1:0] == 2'b00);
  assign instr_ready = (state == IDLE);
  assign rd_data     = rf[rd_addr];

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      // NOTE: every register in an always_ff is updated with <= so all
      // flops sample pre-edge values, independent of statement order.
      state <= next_state;
    end
  end

  // Next-state logic; an illegal accept leaves the FSM in IDLE.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a variable
    // unassigned and infers a latch.
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          accept = 1'b1;
          if (legal) next_state = READ;
        end
      end
      READ:    next_state = EXEC;
      EXEC:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Register file: host loads only in IDLE, datapath writeback at the end of EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the register file is reset explicitly because readback must
      // show zeros after reset; it is flops, not an inferred RAM macro.
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (state == IDLE && ld_en) rf[ld_addr] <= ld_data;
      if (state == EXEC) rf[rd_q] <= alu_result;
    end
  end

  // Issue registers: control fields latched at accept, operands read in READ.
  // A same-edge host load is already in rf by the time READ samples it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_q           <= '0;
      rs2_q           <= '0;
      rd_q            <= '0;
      alu_inp1        <= '0;
      alu_inp2        <= '0;
      alu_shiftImm    <= '0;
      alu_selShiftAmt <= 1'b0;
      alu_oper        <= '0;
      alu_selOut      <= 1'b0;
    end else begin
      if (accept && legal) begin
        alu_selOut      <= instr[15];
        alu_oper        <= instr[14:12];
        alu_selShiftAmt <= instr[11];
        rd_q            <= instr[10:8];
        rs1_q           <= instr[7:5];
        rs2_q           <= instr[4:2];
        alu_shiftImm    <= instr[4:2];
      end
      if (state == READ) begin
        alu_inp1 <= rf[rs1_q];
        alu_inp2 <= rf[rs2_q];
      end
    end
  end

  // Retire/error status: done and err are single-cycle pulses, never together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      retired <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (accept && !legal) err <= 1'b1;
      if (state == EXEC) begin
        done    <= 1'b1;
        result  <= alu_result;
        retired <= retired + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives alu_issue_ctrl with directed and random
// instructions; a transaction-level model (register array, retire counter and
// a behavioural datapath) supplies every expected value.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  alu_inp1;
  logic [7:0]  alu_inp2;
  logic [2:0]  alu_shiftImm;
  logic        alu_selShiftAmt;
  logic [2:0]  alu_oper;
  logic        alu_selOut;
  logic [7:0]  alu_result;
  logic        done;
  logic [7:0]  result;
  logic        err;
  logic [7:0]  retired;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rf_m [8];
  logic [7:0] ret_m;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NREG(8), .W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_ready     (instr_ready),
    .ld_en           (ld_en),
    .ld_addr         (ld_addr),
    .ld_data         (ld_data),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .alu_inp1        (alu_inp1),
    .alu_inp2        (alu_inp2),
    .alu_shiftImm    (alu_shiftImm),
    .alu_selShiftAmt (alu_selShiftAmt),
    .alu_oper        (alu_oper),
    .alu_selOut      (alu_selOut),
    .alu_result      (alu_result),
    .done            (done),
    .result          (result),
    .err             (err),
    .retired         (retired)
  );

  // Behavioural shifter/ALU standing in for the real datapath.
  function automatic logic [7:0] dp(input logic sel, input logic [2:0] op,
                                    input logic ssa, input logic [2:0] imm,
                                    input logic [7:0] a, input logic [7:0] b);
    logic [2:0]        amt;
    logic signed [7:0] sa;
    amt = ssa ? imm : b[2:0];
    sa  = a;
    if (!sel) begin
      case (op)
        3'd1:    return a + b;
        3'd2:    return a - b;
        3'd3:    return a & b;
        3'd4:    return a | b;
        3'd5:    return a ^ b;
        default: return a;
      endcase
    end else begin
      case (op)
        3'd0:    return a << amt;
        3'd1:    return 8'(sa >>> amt);
        3'd2:    return a >> amt;
        default: return a;
      endcase
    end
  endfunction

  always_comb alu_result = dp(alu_selOut, alu_oper, alu_selShiftAmt, alu_shiftImm,
                              alu_inp1, alu_inp2);

  function automatic logic [15:0] enc(input logic sel, input logic [2:0] op,
                                      input logic ssa, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {sel, op, ssa, rd, rs1, rs2, 2'b00};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] v);
    rd_addr = a;
    #1 v = rd_data;
  endtask

  task automatic check_all_regs(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      check($sformatf("%s_r%0d", tag, i), v, rf_m[i]);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    rf_m[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Starts in the READ cycle (just after the accepting edge, valid dropped)
  // and ends in the done cycle. junk: host loads offered while busy.
  task automatic complete(input logic [15:0] ins, input logic junk);
    logic [7:0] exp, a_exp, b_exp, v;
    a_exp = rf_m[ins[7:5]];
    b_exp = rf_m[ins[4:2]];
    exp   = dp(ins[15], ins[14:12], ins[11], ins[4:2], a_exp, b_exp);
    check("read_ready", instr_ready, 0);
    check("read_done", done, 0);
    if (junk) begin
      ld_en = 1'b1; ld_addr = 3'($urandom_range(0, 7)); ld_data = 8'($urandom);
    end
    @(negedge clk);
    check("exec_inp1", alu_inp1, a_exp);
    check("exec_inp2", alu_inp2, b_exp);
    check("exec_imm", alu_shiftImm, ins[4:2]);
    check("exec_oper", alu_oper, ins[14:12]);
    check("exec_sel", alu_selOut, ins[15]);
    check("exec_ssa", alu_selShiftAmt, ins[11]);
    check("exec_ready", instr_ready, 0);
    check("exec_done", done, 0);
    if (junk) begin
      ld_en = 1'b1; ld_addr = 3'($urandom_range(0, 7)); ld_data = 8'($urandom);
    end
    @(negedge clk);
    ld_en = 1'b0;
    rf_m[ins[10:8]] = exp;
    ret_m = ret_m + 8'd1;
    check("done", done, 1);
    check("done_err", err, 0);
    check("done_ready", instr_ready, 1);
    check("result", result, exp);
    check("retired", retired, ret_m);
    check("hold_inp1", alu_inp1, a_exp);
    read_reg(ins[10:8], v);
    check("wb", v, exp);
    if (junk) check_all_regs("junk");
  endtask

  // Offers one instruction (optionally with a same-cycle host load) and
  // follows it to retirement or rejection.
  task automatic run(input logic [15:0] ins, input logic do_ld, input logic [2:0] la,
                     input logic [7:0] ldv, input logic junk);
    logic illegal;
    illegal = (ins[14:12] > 3'd5) || (ins[1:0] != 2'b00);
    @(negedge clk);
    instr_valid = 1'b1; instr = ins;
    ld_en = do_ld; ld_addr = la; ld_data = ldv;
    check("offer_ready", instr_ready, 1);
    @(posedge clk);
    if (do_ld) rf_m[la] = ldv;
    @(negedge clk);
    instr_valid = 1'b0; ld_en = 1'b0;
    if (illegal) begin
      check("err", err, 1);
      check("err_done", done, 0);
      check("err_ready", instr_ready, 1);
      check("err_retired", retired, ret_m);
      check_all_regs("err");
      @(negedge clk);
      check("err_clear", err, 0);
      check("err_nodone", done, 0);
    end else begin
      complete(ins, junk);
    end
  endtask

  // Two legal instructions offered with valid held high throughout.
  task automatic b2b(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] exp_a;
    @(negedge clk);
    instr_valid = 1'b1; instr = a;
    check("b2b_ready0", instr_ready, 1);
    @(posedge clk);
    exp_a = dp(a[15], a[14:12], a[11], a[4:2], rf_m[a[7:5]], rf_m[a[4:2]]);
    @(negedge clk);
    instr = b;
    check("b2b_busy1", instr_ready, 0);
    @(negedge clk);
    check("b2b_busy2", instr_ready, 0);
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 8'h5a;
    @(negedge clk);
    ld_en = 1'b0;
    rf_m[a[10:8]] = exp_a;
    ret_m = ret_m + 8'd1;
    check("b2b_done", done, 1);
    check("b2b_ready", instr_ready, 1);
    check("b2b_result", result, exp_a);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    complete(b, 1'b0);
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] ins;
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    ret_m = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_retired", retired, 0);
    check("rst_inp1", alu_inp1, 0);
    check("rst_oper", alu_oper, 0);
    check_all_regs("rst");
    reset = 1'b0;

    // ADD 80+20 into R3
    load(3'd1, 8'd80);
    load(3'd2, 8'd20);
    run(enc(1'b0, 3'd1, 1'b0, 3'd3, 3'd1, 3'd2), 1'b0, 3'd0, 8'd0, 1'b0);
    read_reg(3'd3, v); check("add_r3", v, 100);
    check("add_ret", retired, 1);
    // arithmetic right shift by immediate 2 into R4
    run(enc(1'b1, 3'd1, 1'b1, 3'd4, 3'd1, 3'd2), 1'b0, 3'd0, 8'd0, 1'b0);
    read_reg(3'd4, v); check("shr_r4", v, 20);
    // SUB wraps below zero, ADD wraps above 255
    load(3'd1, 8'd15);
    load(3'd2, 8'd26);
    run(enc(1'b0, 3'd2, 1'b0, 3'd5, 3'd1, 3'd2), 1'b0, 3'd0, 8'd0, 1'b0);
    read_reg(3'd5, v); check("sub_r5", v, 245);
    load(3'd1, 8'd150);
    load(3'd2, 8'd150);
    run(enc(1'b0, 3'd1, 1'b0, 3'd6, 3'd1, 3'd2), 1'b0, 3'd0, 8'd0, 1'b0);
    read_reg(3'd6, v); check("add_r6", v, 44);
    // illegal opcode and non-zero reserved bits
    run(enc(1'b0, 3'd6, 1'b0, 3'd3, 3'd1, 3'd2), 1'b0, 3'd0, 8'd0, 1'b0);
    run(enc(1'b0, 3'd1, 1'b0, 3'd3, 3'd1, 3'd2) | 16'h0001, 1'b0, 3'd0, 8'd0, 1'b0);
    // back-to-back issue with a host load during EXEC that must be ignored
    b2b(enc(1'b0, 3'd1, 1'b0, 3'd7, 3'd1, 3'd2), enc(1'b0, 3'd2, 1'b0, 3'd0, 3'd7, 3'd1));
    read_reg(3'd2, v); check("exec_ld_ignored", v, 150);

    // reset during EXEC of ADD rd=3
    @(negedge clk);
    instr_valid = 1'b1; instr = enc(1'b0, 3'd1, 1'b0, 3'd3, 3'd1, 3'd2);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    ret_m = '0;
    #1;
    check("mid_rst_ready", instr_ready, 1);
    check("mid_rst_retired", retired, 0);
    check("mid_rst_inp1", alu_inp1, 0);
    check_all_regs("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_nodone", done, 0);
      check("mid_rst_ready2", instr_ready, 1);
    end
    read_reg(3'd3, v); check("mid_rst_r3", v, 0);

    // host load of rs1 in the accept cycle feeds READ
    load(3'd2, 8'd7);
    run(enc(1'b0, 3'd1, 1'b0, 3'd3, 3'd1, 3'd1), 1'b1, 3'd1, 8'd33, 1'b0);
    read_reg(3'd3, v); check("ld_fwd_r3", v, 66);

    // random traffic; enough retirements to wrap the counter past 255
    for (int n = 0; n < 320; n++) begin
      ins = enc(1'($urandom), 3'($urandom_range(0, 5)), 1'($urandom),
                3'($urandom), 3'($urandom), 3'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) ins[14:12] = 3'($urandom_range(6, 7));
        else ins[1:0] = 2'($urandom_range(1, 3));
        run(ins, 1'b0, 3'd0, 8'd0, 1'b0);
      end else begin
        run(ins, 1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 3) == 0) load(3'($urandom), 8'($urandom));
    end
    check_all_regs("final");
    check("final_retired", retired, ret_m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
